// File: rtl/sbox_arbiter.sv
// Shares LANES Rijndael S-box lookups between the round datapath (128-bit SubBytes)
// and key expansion (32-bit SubWord), round-robin arbitrated, LANES bytes per cycle.
module sbox_arbiter #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         data_req,
    input  logic [127:0] data_in,
    output logic         data_ack,
    output logic         data_done,
    output logic [127:0] data_out,
    input  logic         key_req,
    input  logic [31:0]  key_in,
    output logic         key_ack,
    output logic         key_done,
    output logic [31:0]  key_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, DATA_RUN, KEY_RUN} state_t;

    localparam logic [3:0] DATA_LAST = 4'(16 / LANES - 1);
    localparam logic [3:0] KEY_LAST  = 4'(4 / LANES - 1);

    state_t       state, state_next;
    logic         last_key;
    logic [3:0]   cnt;
    logic [127:0] operand;
    logic [127:0] work;
    logic [127:0] work_next;
    logic         grant_key, grant_data;
    logic         last_chunk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = v;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign grant_key  = key_req && (!data_req || !last_key);
    assign grant_data = data_req && !grant_key;
    assign last_chunk = (state == DATA_RUN && cnt == DATA_LAST) ||
                        (state == KEY_RUN  && cnt == KEY_LAST);
    assign busy       = (state != IDLE);

    always_comb begin
        work_next = work;
        for (int unsigned l = 0; l < LANES; l++) begin
            work_next[(32'(cnt) * LANES + l) * 8 +: 8] =
                sbox(operand[(32'(cnt) * LANES + l) * 8 +: 8]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_key)       state_next = KEY_RUN;
                else if (grant_data) state_next = DATA_RUN;
            end
            DATA_RUN, KEY_RUN: begin
                if (last_chunk) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_key  <= 1'b0;
            cnt       <= '0;
            operand   <= '0;
            work      <= '0;
            data_out  <= '0;
            key_out   <= '0;
            data_ack  <= 1'b0;
            key_ack   <= 1'b0;
            data_done <= 1'b0;
            key_done  <= 1'b0;
        end else begin
            data_ack  <= (state == IDLE) && grant_data;
            key_ack   <= (state == IDLE) && grant_key;
            data_done <= (state == DATA_RUN) && last_chunk;
            key_done  <= (state == KEY_RUN) && last_chunk;
            if (state == IDLE) begin
                if (grant_key || grant_data) begin
                    operand  <= grant_key ? {96'h0, key_in} : data_in;
                    cnt      <= '0;
                    last_key <= grant_key;
                end
            end else begin
                work <= work_next;
                // cnt wraps to 0 on the last chunk so lane indices never run past byte 15
                if (last_chunk) begin
                    cnt <= '0;
                    if (state == DATA_RUN) data_out <= work_next;
                    else                   key_out  <= work_next[31:0];
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter: LANES=4/2/1 instances, table vectors plus
// arbitration, held-request and mid-job reset sequences.
module tb_sbox_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         data_req  [3];
    logic [127:0] data_in   [3];
    logic         data_ack  [3];
    logic         data_done [3];
    logic [127:0] data_out  [3];
    logic         key_req   [3];
    logic [31:0]  key_in    [3];
    logic         key_ack   [3];
    logic         key_done  [3];
    logic [31:0]  key_out   [3];
    logic         busy      [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sbox_arbiter #(.LANES(4)) dut4 (
        .clk(clk), .rst(rst),
        .data_req(data_req[0]), .data_in(data_in[0]), .data_ack(data_ack[0]),
        .data_done(data_done[0]), .data_out(data_out[0]),
        .key_req(key_req[0]), .key_in(key_in[0]), .key_ack(key_ack[0]),
        .key_done(key_done[0]), .key_out(key_out[0]), .busy(busy[0])
    );
    sbox_arbiter #(.LANES(2)) dut2 (
        .clk(clk), .rst(rst),
        .data_req(data_req[1]), .data_in(data_in[1]), .data_ack(data_ack[1]),
        .data_done(data_done[1]), .data_out(data_out[1]),
        .key_req(key_req[1]), .key_in(key_in[1]), .key_ack(key_ack[1]),
        .key_done(key_done[1]), .key_out(key_out[1]), .busy(busy[1])
    );
    sbox_arbiter #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst),
        .data_req(data_req[2]), .data_in(data_in[2]), .data_ack(data_ack[2]),
        .data_done(data_done[2]), .data_out(data_out[2]),
        .key_req(key_req[2]), .key_in(key_in[2]), .key_ack(key_ack[2]),
        .key_done(key_done[2]), .key_out(key_out[2]), .busy(busy[2])
    );

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_req[k] = 1'b0; key_req[k] = 1'b0;
            data_in[k] = '0;    key_in[k] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Edge count c: the capture edge E0 is c=1, so a job of R RUN cycles shows done at c=R+1.
    task automatic run_job(input int k, input bit is_key, input logic [127:0] din,
                           output int lat, output int ack_cyc, output logic busy_ack,
                           output logic [127:0] res);
        int c;
        lat = -1; ack_cyc = -1; busy_ack = 1'b0; res = '0; c = 0;
        @(negedge clk);
        if (is_key) begin key_in[k] = din[31:0]; key_req[k] = 1'b1; end
        else        begin data_in[k] = din;      data_req[k] = 1'b1; end
        while (lat < 0 && c < 40) begin
            @(posedge clk); #1; c++;
            if (is_key ? key_ack[k] : data_ack[k]) begin
                ack_cyc = c; busy_ack = busy[k];
                key_req[k] = 1'b0; data_req[k] = 1'b0;
            end
            if (is_key ? key_done[k] : data_done[k]) begin
                lat = c;
                res = is_key ? {96'h0, key_out[k]} : data_out[k];
            end
        end
        key_req[k] = 1'b0; data_req[k] = 1'b0;
    endtask

    localparam logic [127:0] DATA_VEC = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] DATA_EXP = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [31:0]  KEY_VEC  = 32'hcf4f3c09;
    localparam logic [31:0]  KEY_EXP  = 32'h8a84eb01;

    initial begin
        vec_t         vecs [5];
        int           lat, ack_cyc, lanes, runs, c;
        logic         busy_ack;
        logic [127:0] res, other_before;

        vecs[0] = '{1'b1, {96'h0, KEY_VEC}, {96'h0, KEY_EXP}};
        vecs[1] = '{1'b0, DATA_VEC, DATA_EXP};
        vecs[2] = '{1'b1, 128'h0000_0000_0000_0000_0000_0000_5353_5353, 128'h0000_0000_0000_0000_0000_0000_eded_eded};
        vecs[3] = '{1'b0, {32{4'hf}}, {16{8'h16}}};
        vecs[4] = '{1'b1, 128'h0, 128'h0000_0000_0000_0000_0000_0000_6363_6363};

        do_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_data_out[%0d]", k), data_out[k], '0);
            chk($sformatf("reset_key_out[%0d]", k), {96'h0, key_out[k]}, '0);
            chk($sformatf("reset_flags[%0d]", k),
                {123'h0, busy[k], data_ack[k], key_ack[k], data_done[k], key_done[k]}, '0);
        end

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 3; k++) begin
                lanes = (k == 0) ? 4 : (k == 1) ? 2 : 1;
                runs  = vecs[v].is_key ? 4 / lanes : 16 / lanes;
                other_before = vecs[v].is_key ? data_out[k] : {96'h0, key_out[k]};
                run_job(k, vecs[v].is_key, vecs[v].din, lat, ack_cyc, busy_ack, res);
                chk($sformatf("vec%0d_L%0d_out", v, lanes), res, vecs[v].exp);
                chk($sformatf("vec%0d_L%0d_latency", v, lanes), 128'(lat), 128'(runs + 1));
                chk($sformatf("vec%0d_L%0d_ack_cycle", v, lanes), 128'(ack_cyc), 128'd1);
                chk($sformatf("vec%0d_L%0d_busy_ack_done", v, lanes),
                    {126'h0, busy_ack, busy[k]}, 128'b10);
                chk($sformatf("vec%0d_L%0d_other_out_held", v, lanes),
                    vecs[v].is_key ? data_out[k] : {96'h0, key_out[k]}, other_before);
            end
        end

        // Both requesters hold req and re-request after done: grants must alternate K,D,K,D.
        begin
            logic grants [4];
            int   ng;
            do_reset();
            @(negedge clk);
            data_in[0] = DATA_VEC; key_in[0] = KEY_VEC;
            data_req[0] = 1'b1;    key_req[0] = 1'b1;
            ng = 0; c = 0;
            for (int g = 0; g < 4; g++) grants[g] = 1'b0;
            while (ng < 4 && c < 100) begin
                @(posedge clk); #1; c++;
                if (key_ack[0])  begin if (ng < 4) grants[ng] = 1'b1; ng++; key_req[0] = 1'b0; end
                if (data_ack[0]) begin if (ng < 4) grants[ng] = 1'b0; ng++; data_req[0] = 1'b0; end
                if (key_done[0])  key_req[0] = 1'b1;
                if (data_done[0]) data_req[0] = 1'b1;
            end
            data_req[0] = 1'b0; key_req[0] = 1'b0;
            chk("rr_grant_count", 128'(ng), 128'd4);
            chk("rr_grant_order", {124'h0, grants[0], grants[1], grants[2], grants[3]}, 128'b1010);
        end

        // Data request raised during a key job is granted at the first IDLE edge after key_done.
        begin
            int kd, da, dd;
            do_reset();
            @(negedge clk);
            key_in[0] = KEY_VEC; key_req[0] = 1'b1;
            kd = -1; da = -1; dd = -1; c = 0;
            while (dd < 0 && c < 40) begin
                @(posedge clk); #1; c++;
                if (key_ack[0]) begin
                    key_req[0] = 1'b0;
                    data_in[0] = DATA_VEC; data_req[0] = 1'b1;
                end
                if (key_done[0]) kd = c;
                if (data_ack[0]) begin da = c; data_req[0] = 1'b0; end
                if (data_done[0]) dd = c;
            end
            data_req[0] = 1'b0;
            chk("held_key_done_cycle", 128'(kd), 128'd2);
            chk("held_data_ack_cycle", 128'(da), 128'(kd + 1));
            chk("held_data_done_cycle", 128'(dd), 128'(da + 4));
            chk("held_data_out", data_out[0], DATA_EXP);
            chk("held_key_out", {96'h0, key_out[0]}, {96'h0, KEY_EXP});
        end

        // Reset during the second DATA_RUN cycle abandons the job asynchronously.
        begin
            int dones;
            @(negedge clk);
            data_in[0] = {32{4'ha}}; data_req[0] = 1'b1;
            c = 0;
            while (c < 2) begin
                @(posedge clk); #1; c++;
                if (data_ack[0]) data_req[0] = 1'b0;
            end
            rst = 1'b1;
            #1;
            chk("midrst_data_out", data_out[0], '0);
            chk("midrst_key_out", {96'h0, key_out[0]}, '0);
            chk("midrst_busy", {127'h0, busy[0]}, '0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            dones = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (data_done[0] || busy[0]) dones++;
            end
            chk("midrst_no_done", 128'(dones), 128'd0);
            run_job(0, 1'b0, DATA_VEC, lat, ack_cyc, busy_ack, res);
            chk("midrst_rerun_out", res, DATA_EXP);
            chk("midrst_rerun_latency", 128'(lat), 128'd5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_arbiter.md
# sbox_arbiter

Time-shares a bank of LANES Rijndael S-box lookups between the two consumers of SubBytes in the AES core. The first consumer is the round datapath, which applies SubBytes to a 128-bit state. The second is key expansion, which applies SubWord to a 32-bit word. The block arbitrates between the two requesters round-robin, sequences each job LANES bytes per cycle through the shared lookups, and returns the substituted result with a done pulse.

## Interface
- LANES, 4, number of S-box lookups instantiated and bytes processed per cycle; legal values 1, 2, 4.
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- data_req  in  1  round datapath requests a SubBytes job; held high with data_in stable until data_ack.
- data_in  in  128  state to substitute; byte i = bits [8i+7:8i].
- data_ack  out  1  one-cycle pulse, cycle after data_in was captured.
- data_done  out  1  one-cycle pulse, data_out valid from this cycle.
- data_out  out  128  substituted state; byte i = S(data_in byte i); holds until the next data job completes.
- key_req  in  1  key expansion requests a SubWord job; same rules as data_req.
- key_in  in  32  word to substitute; byte i = bits [8i+7:8i].
- key_ack  out  1  one-cycle pulse, cycle after key_in was captured.
- key_done  out  1  one-cycle pulse, key_out valid from this cycle.
- key_out  out  32  substituted word; byte i = S(key_in byte i); holds until the next key job completes.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, DATA_RUN, KEY_RUN.
- Job length:
  - data job = 16/LANES RUN cycles (LANES=4: 4 cycles);
  - key job = 4/LANES RUN cycles (LANES=4: 1 cycle).
- IDLE, arbitration at each edge:
  - if only one req is high, grant it;
  - if both are high, grant the requester not in last_grant;
  - last_grant resets to DATA, so key wins the first simultaneous request.
- On grant:
  - capture the granted input into a 128-bit operand register (key uses the low 32 bits);
  - clear the byte counter cnt;
  - update last_grant;
  - go to the matching RUN state;
  - set the matching ack for the following cycle.
- RUN, each edge:
  - bytes [cnt*LANES .. cnt*LANES+LANES-1] of the operand pass through the LANES S-boxes into the same byte positions of a working register;
  - cnt increments;
  - processing is byte 0 first, ascending.
- RUN, last chunk edge:
  - copy the working register, with the final chunk merged, into data_out or key_out;
  - pulse the matching done in the next cycle;
  - return to IDLE.
- Requesters:
  - a requester drops req in the cycle it sees ack;
  - req is never sampled in RUN states;
  - a req still high on return to IDLE starts a new job.
- The other requester may hold req throughout a job; it is granted at the first IDLE edge.
- Round-robin guarantees neither requester waits more than one job of the other.
- Lane outputs not selected by cnt are ignored; S-box lookup is purely combinational.

## Timing
- Reset values:
  - state IDLE, last_grant DATA, cnt 0;
  - data_ack, key_ack, data_done, key_done, busy all 0;
  - data_out 128'h0, key_out 32'h0.
- Latency, LANES=4, edge E0 = capture edge in IDLE:
  - ack high in cycle E0..E1;
  - key: done high in cycle E1..E2, key_out updated at E1;
  - data: done high in cycle E4..E5, data_out updated at E4.
- Back-to-back: IDLE lasts at least one cycle between jobs, because the edge that leaves RUN cannot also grant. Key-then-data minimum spacing is 2 cycles edge-to-edge.
- ack and done are never high in the same cycle for the same requester when LANES < 4. For a key job at LANES=4, key_ack and key_done fall in consecutive cycles.
- Reset mid-job: the job is abandoned, no done pulse, outputs return to reset values immediately (asynchronous).
- busy rises the cycle after the grant edge and falls the cycle after the last chunk edge.

## Test plan
- Key job, LANES=4: key_in 32'hcf4f3c09 -> key_ack 1 cycle later, key_done next cycle, key_out 32'h8a84eb01.
- Data job: data_in 128'h0f0e0d0c0b0a09080706050403020100 -> data_done after 4 RUN cycles, data_out 128'h76abd7fe2b670130c56f6bf27b777c63.
- Simultaneous requests from reset, both held: key granted first, then data, then key again. No requester is granted twice in a row while the other waits.
- Data req held through a key job: data granted at the first IDLE edge after key_done; data_out correct, key_out unchanged.
- Reset asserted in DATA_RUN cycle 2 -> no data_done; data_out 0, busy 0; a new job after release completes correctly.
- Repeat the data and key vectors at LANES=1 and LANES=2: same outputs, data latency 16 and 8 RUN cycles, key latency 4 and 2.
